// File: rtl/tx_arbiter_pkg.sv
// Shared types for the TL TX arbiter: source tags, flow-control classes,
// dispatcher states and the tag-to-class / tag-to-grant mappings.
package tx_arbiter_pkg;

    localparam int unsigned SRC_W   = 3;
    localparam int unsigned NUM_SRC = 4;

    typedef enum logic [SRC_W-1:0] {
        NO_SOURCE     = 3'd0,
        AXI_MASTER_P  = 3'd1,
        AXI_MASTER_NP = 3'd2,
        AXI_SLAVE_CPL = 3'd3,
        RX_ROUTER_CPL = 3'd4
    } tx_src_t;

    typedef enum logic [1:0] {
        FC_P   = 2'd0,
        FC_NP  = 2'd1,
        FC_CPL = 2'd2
    } fc_class_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_XMIT
    } disp_state_t;

    function automatic fc_class_t src2class(input tx_src_t src);
        case (src)
            AXI_MASTER_NP:                src2class = FC_NP;
            AXI_SLAVE_CPL, RX_ROUTER_CPL: src2class = FC_CPL;
            default:                      src2class = FC_P;
        endcase
    endfunction

    function automatic logic [NUM_SRC-1:0] src2onehot(input tx_src_t src);
        case (src)
            AXI_MASTER_P:  src2onehot = 4'b0001;
            AXI_MASTER_NP: src2onehot = 4'b0010;
            AXI_SLAVE_CPL: src2onehot = 4'b0100;
            RX_ROUTER_CPL: src2onehot = 4'b1000;
            default:       src2onehot = '0;
        endcase
    endfunction

endpackage

// File: rtl/tx_req_packer.sv
// Packs the per-source request pulses into consecutive recorder slots in
// fixed priority (ascending bit) order and reports how many were packed.
module tx_req_packer
    import tx_arbiter_pkg::*;
(
    input  logic [NUM_SRC-1:0] req_valid,
    output logic [2:0]         wr_mode,
    output tx_src_t            wr_data [NUM_SRC]
);

    logic [2:0] slot_cnt;

    always_comb begin
        slot_cnt = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            wr_data[i] = NO_SOURCE;
        end
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (req_valid[i]) begin
                wr_data[slot_cnt[1:0]] = tx_src_t'(SRC_W'(i + 1));
                slot_cnt               = slot_cnt + 3'd1;
            end
        end
        wr_mode = slot_cnt;
    end

endmodule

// File: rtl/tx_seq_dispatcher.sv
// TL TX arbiter control: pushes arrival-ordered source tags into the sequence
// recorder and grants the oldest one once its flow-control credits allow.
module tx_seq_dispatcher
    import tx_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 10,
    parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int unsigned HDR_CR_W   = 8,
    parameter int unsigned DATA_CR_W  = 12
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [3:0]             req_valid,
    output logic                   req_ready,
    output logic                   seq_wr_en,
    output logic [2:0]             seq_wr_mode,
    output logic [SRC_W-1:0]       seq_wr_data_1,
    output logic [SRC_W-1:0]       seq_wr_data_2,
    output logic [SRC_W-1:0]       seq_wr_data_3,
    output logic [SRC_W-1:0]       seq_wr_data_4,
    input  logic [ADDR_WIDTH:0]    seq_available,
    input  logic                   seq_full,
    input  logic                   seq_empty,
    output logic                   seq_rd_en,
    output logic [1:0]             seq_rd_mode,
    input  logic [SRC_W-1:0]       seq_rd_data_1,
    input  logic [HDR_CR_W-1:0]    cr_p_hdr,
    input  logic [HDR_CR_W-1:0]    cr_np_hdr,
    input  logic [HDR_CR_W-1:0]    cr_cpl_hdr,
    input  logic [DATA_CR_W-1:0]   cr_p_data,
    input  logic [DATA_CR_W-1:0]   cr_np_data,
    input  logic [DATA_CR_W-1:0]   cr_cpl_data,
    input  logic [4*DATA_CR_W-1:0] src_data_need,
    input  logic                   tlp_done,
    output logic [3:0]             grant,
    output logic                   cr_consume_vld,
    output logic [1:0]             cr_consume_class,
    output logic [DATA_CR_W-1:0]   cr_consume_data,
    output logic                   proto_err
);

    logic [2:0] wr_cnt;
    tx_src_t    pk_data [NUM_SRC];

    tx_req_packer u_packer (
        .req_valid (req_valid),
        .wr_mode   (wr_cnt),
        .wr_data   (pk_data)
    );

    assign req_ready     = (32'(seq_available) >= 32'(wr_cnt)) && !seq_full;
    assign seq_wr_en     = (wr_cnt != 3'd0) && req_ready;
    assign seq_wr_mode   = wr_cnt;
    assign seq_wr_data_1 = pk_data[0];
    assign seq_wr_data_2 = pk_data[1];
    assign seq_wr_data_3 = pk_data[2];
    assign seq_wr_data_4 = pk_data[3];
    assign seq_rd_mode   = 2'b01;

    disp_state_t          state_q, state_d;
    tx_src_t              head_q, head_d;
    logic [3:0]           grant_q, grant_d;
    logic                 cr_vld_q, cr_vld_d;
    fc_class_t            cr_class_q, cr_class_d;
    logic [DATA_CR_W-1:0] cr_data_q, cr_data_d;
    logic                 err_q, err_d;

    fc_class_t            head_class;
    logic [HDR_CR_W-1:0]  hdr_sel;
    logic [DATA_CR_W-1:0] data_sel;
    logic [DATA_CR_W-1:0] need_sel;
    logic                 cr_ok;

    always_comb begin
        head_class = src2class(head_q);
        case (head_class)
            FC_NP:   begin hdr_sel = cr_np_hdr;  data_sel = cr_np_data;  end
            FC_CPL:  begin hdr_sel = cr_cpl_hdr; data_sel = cr_cpl_data; end
            default: begin hdr_sel = cr_p_hdr;   data_sel = cr_p_data;   end
        endcase
        case (head_q)
            AXI_MASTER_P:  need_sel = src_data_need[0*DATA_CR_W +: DATA_CR_W];
            AXI_MASTER_NP: need_sel = src_data_need[1*DATA_CR_W +: DATA_CR_W];
            AXI_SLAVE_CPL: need_sel = src_data_need[2*DATA_CR_W +: DATA_CR_W];
            RX_ROUTER_CPL: need_sel = src_data_need[3*DATA_CR_W +: DATA_CR_W];
            default:       need_sel = '0;
        endcase
        cr_ok = (hdr_sel != '0) && (data_sel >= need_sel);
    end

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        grant_d    = grant_q;
        cr_vld_d   = 1'b0;
        cr_class_d = cr_class_q;
        cr_data_d  = cr_data_q;
        err_d      = err_q;
        seq_rd_en  = 1'b0;

        if (tlp_done && (state_q != S_XMIT)) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!seq_empty) begin
                    seq_rd_en = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            // The recorder registers its output on the pop edge, so the tag is
            // already stable here without waiting an extra cycle.
            S_FETCH: begin
                head_d = tx_src_t'(seq_rd_data_1);
                if (seq_rd_data_1 == NO_SOURCE) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cr_ok) begin
                    grant_d    = src2onehot(head_q);
                    cr_vld_d   = 1'b1;
                    cr_class_d = head_class;
                    cr_data_d  = need_sel;
                    state_d    = S_XMIT;
                end
            end
            S_XMIT: begin
                if (tlp_done) begin
                    grant_d = '0;
                    if (!seq_empty) begin
                        seq_rd_en = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q    <= S_IDLE;
            head_q     <= NO_SOURCE;
            grant_q    <= '0;
            cr_vld_q   <= 1'b0;
            cr_class_q <= FC_P;
            cr_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            grant_q    <= grant_d;
            cr_vld_q   <= cr_vld_d;
            cr_class_q <= cr_class_d;
            cr_data_q  <= cr_data_d;
            err_q      <= err_d;
        end
    end

    assign grant            = grant_q;
    assign cr_consume_vld   = cr_vld_q;
    assign cr_consume_class = cr_class_q;
    assign cr_consume_data  = cr_data_q;
    assign proto_err        = err_q;

endmodule

// File: tb/tb_tx_seq_dispatcher.sv
// Bench for tx_seq_dispatcher: a behavioural sequence recorder plus an
// arrival-order scoreboard of expected grants and credit consumption.
module tb_tx_seq_dispatcher;
    import tx_arbiter_pkg::*;

    localparam int DEPTH = 10;
    localparam int AW    = 4;
    localparam int HW    = 8;
    localparam int DW    = 12;

    logic clk  = 1'b0;
    logic arst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]    req_valid = '0;
    logic          req_ready, seq_wr_en, seq_rd_en, seq_full, seq_empty;
    logic [2:0]    seq_wr_mode;
    logic [2:0]    seq_wr_data_1, seq_wr_data_2, seq_wr_data_3, seq_wr_data_4;
    logic [AW:0]   seq_available;
    logic [1:0]    seq_rd_mode;
    logic [2:0]    seq_rd_data_1;
    logic [HW-1:0] hdr [3];
    logic [DW-1:0] dcr [3];
    logic [DW-1:0] need [4];
    logic [4*DW-1:0] src_data_need;
    logic          tlp_done = 1'b0;
    logic [3:0]    grant;
    logic          cr_consume_vld, proto_err;
    logic [1:0]    cr_consume_class;
    logic [DW-1:0] cr_consume_data;

    assign src_data_need = {need[3], need[2], need[1], need[0]};

    tx_seq_dispatcher #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .HDR_CR_W(HW), .DATA_CR_W(DW)) dut (
        .clk(clk), .arst(arst), .req_valid(req_valid), .req_ready(req_ready),
        .seq_wr_en(seq_wr_en), .seq_wr_mode(seq_wr_mode),
        .seq_wr_data_1(seq_wr_data_1), .seq_wr_data_2(seq_wr_data_2),
        .seq_wr_data_3(seq_wr_data_3), .seq_wr_data_4(seq_wr_data_4),
        .seq_available(seq_available), .seq_full(seq_full), .seq_empty(seq_empty),
        .seq_rd_en(seq_rd_en), .seq_rd_mode(seq_rd_mode), .seq_rd_data_1(seq_rd_data_1),
        .cr_p_hdr(hdr[0]), .cr_np_hdr(hdr[1]), .cr_cpl_hdr(hdr[2]),
        .cr_p_data(dcr[0]), .cr_np_data(dcr[1]), .cr_cpl_data(dcr[2]),
        .src_data_need(src_data_need), .tlp_done(tlp_done), .grant(grant),
        .cr_consume_vld(cr_consume_vld), .cr_consume_class(cr_consume_class),
        .cr_consume_data(cr_consume_data), .proto_err(proto_err)
    );

    // Sequence recorder: circular buffer with a registered read port.
    logic [2:0] mem [DEPTH];
    logic [2:0] wdat [4];
    logic [2:0] rd_q;
    int wp, rp, fcount, nw;

    assign wdat[0] = seq_wr_data_1;
    assign wdat[1] = seq_wr_data_2;
    assign wdat[2] = seq_wr_data_3;
    assign wdat[3] = seq_wr_data_4;
    assign nw            = seq_wr_en ? int'(seq_wr_mode) : 0;
    assign seq_available = 5'(DEPTH - fcount);
    assign seq_full      = (fcount == DEPTH);
    assign seq_empty     = (fcount == 0);
    assign seq_rd_data_1 = rd_q;

    always @(posedge clk or negedge arst) begin
        if (!arst) begin
            wp <= 0; rp <= 0; fcount <= 0; rd_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (k < nw) mem[(wp + k) % DEPTH] <= wdat[k];
            if (seq_rd_en) begin
                rd_q <= mem[rp];
                rp   <= (rp + 1) % DEPTH;
            end
            wp     <= (wp + nw) % DEPTH;
            fcount <= fcount + nw - (seq_rd_en ? 1 : 0);
        end
    end

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int hold = 0;

    function automatic int tag_class(input int tag);
        return (tag == 1) ? 0 : (tag == 2) ? 1 : 2;
    endfunction

    function automatic bit cred_ok(input int tag);
        int c;
        c = tag_class(tag);
        return (hdr[c] >= 1) && (dcr[c] >= need[tag - 1]);
    endfunction

    function automatic logic [2:0] wr_slot(input int s);
        case (s)
            0: return seq_wr_data_1;
            1: return seq_wr_data_2;
            2: return seq_wr_data_3;
            default: return seq_wr_data_4;
        endcase
    endfunction

    task automatic set_credits_max();
        for (int c = 0; c < 3; c++) begin
            hdr[c] = '1;
            dcr[c] = '1;
        end
    endtask

    // One clock: check write path before the edge, grant/consume events after.
    task automatic cycle();
        int n, t;
        bit rdy, okp;
        int tg[$];
        logic [3:0] g0;
        logic [2:0] got, expd;
        #1;
        n   = $countones(req_valid);
        rdy = ((DEPTH - fcount) >= n) && (fcount != DEPTH);
        checks++;
        if (req_ready !== rdy) begin
            failures++;
            $display("FAIL req_ready: got %b exp %b (req_valid=%b free=%0d)", req_ready, rdy, req_valid, DEPTH - fcount);
        end
        checks++;
        if (seq_wr_en !== (rdy && n != 0)) begin
            failures++;
            $display("FAIL seq_wr_en: got %b exp %b", seq_wr_en, rdy && n != 0);
        end
        for (int b = 0; b < 4; b++)
            if (req_valid[b]) tg.push_back(b + 1);
        if (n != 0) begin
            checks++;
            if (seq_wr_mode !== 3'(n)) begin
                failures++;
                $display("FAIL seq_wr_mode: got %0d exp %0d", seq_wr_mode, n);
            end
            for (int s = 0; s < 4; s++) begin
                got  = wr_slot(s);
                expd = (s < n) ? 3'(tg[s]) : 3'd0;
                checks++;
                if (got !== expd) begin
                    failures++;
                    $display("FAIL wr_data_%0d: got %0d exp %0d", s + 1, got, expd);
                end
            end
            if (rdy) foreach (tg[i]) exp_q.push_back(tg[i]);
        end
        checks++;
        if (seq_rd_en === 1'b1 && fcount == 0) begin
            failures++;
            $display("FAIL rd_when_empty: seq_rd_en=1 with recorder empty");
        end
        okp = (exp_q.size() > 0) && cred_ok(exp_q[0]);
        g0  = grant;
        @(posedge clk);
        #1;
        if (g0 == 4'b0000 && grant != 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL grant_unexpected: got %b with no queued tag", grant);
            end else begin
                t = exp_q.pop_front();
                if (grant !== 4'(1 << (t - 1))) begin
                    failures++;
                    $display("FAIL grant_order: got %b exp %b", grant, 4'(1 << (t - 1)));
                end
                checks++;
                if (cr_consume_vld !== 1'b1 || cr_consume_class !== 2'(tag_class(t))) begin
                    failures++;
                    $display("FAIL consume: vld=%b class=%0d exp vld=1 class=%0d", cr_consume_vld, cr_consume_class, tag_class(t));
                end
                checks++;
                if (cr_consume_data !== need[t - 1]) begin
                    failures++;
                    $display("FAIL consume_data: got %0d exp %0d", cr_consume_data, need[t - 1]);
                end
                checks++;
                if (!okp) begin
                    failures++;
                    $display("FAIL grant_credits: granted tag %0d without sufficient credits", t);
                end
            end
        end else begin
            checks++;
            if (cr_consume_vld !== 1'b0) begin
                failures++;
                $display("FAIL spurious_consume: got vld=%b exp 0", cr_consume_vld);
            end
        end
    endtask

    // The granted source finishes its TLP after a random number of beats.
    task automatic auto_done();
        if (tlp_done) begin
            tlp_done = 1'b0;
            hold     = $urandom_range(0, 2);
        end else if (grant != 4'b0000) begin
            if (hold == 0) tlp_done = 1'b1;
            else hold--;
        end
    endtask

    task automatic drain(input int max_cycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0 && grant == 4'b0000 && !tlp_done && fcount == 0) begin
                done = 1'b1;
                break;
            end
            auto_done();
            cycle();
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain_timeout: %0d tags still pending, grant=%b", exp_q.size(), grant);
        end
        checks++;
        if (proto_err !== 1'b0) begin
            failures++;
            $display("FAIL proto_err_drain: got %b exp 0", proto_err);
        end
    endtask

    task automatic test_reset();
        arst = 1'b0;
        #12;
        checks++;
        if (grant !== 4'b0 || seq_rd_en !== 1'b0 || cr_consume_vld !== 1'b0 || proto_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: grant=%b rd_en=%b vld=%b err=%b exp all 0", grant, seq_rd_en, cr_consume_vld, proto_err);
        end
        checks++;
        if (req_ready !== 1'b1 || seq_wr_en !== 1'b0 || seq_rd_mode !== 2'b01) begin
            failures++;
            $display("FAIL reset_wr: ready=%b wr_en=%b rd_mode=%b exp 1 0 01", req_ready, seq_wr_en, seq_rd_mode);
        end
        checks++;
        if (dut.head_q !== NO_SOURCE || dut.state_q !== S_IDLE) begin
            failures++;
            $display("FAIL reset_state: head=%0d state=%0d exp 0 0", dut.head_q, dut.state_q);
        end
        @(negedge clk);
        arst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_simultaneous();
        logic [3:0] nxt [3];
        nxt[0] = 4'b0010; nxt[1] = 4'b1000; nxt[2] = 4'b0000;
        set_credits_max();
        req_valid = 4'b1011;
        #1;
        checks++;
        if (seq_wr_mode !== 3'd3 || seq_wr_data_1 !== 3'd1 || seq_wr_data_2 !== 3'd2 ||
            seq_wr_data_3 !== 3'd4 || seq_wr_data_4 !== 3'd0) begin
            failures++;
            $display("FAIL pack_1011: mode=%0d data=%0d,%0d,%0d,%0d exp 3 1,2,4,0", seq_wr_mode,
                     seq_wr_data_1, seq_wr_data_2, seq_wr_data_3, seq_wr_data_4);
        end
        cycle();
        req_valid = 4'b0000;
        cycle();
        cycle();
        checks++;
        if (grant !== 4'b0000) begin
            failures++;
            $display("FAIL latency_early: got grant %b exp 0000", grant);
        end
        cycle();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL latency_first: got grant %b exp 0001", grant);
        end
        for (int k = 0; k < 3; k++) begin
            tlp_done = 1'b1;
            cycle();
            tlp_done = 1'b0;
            checks++;
            if (grant !== 4'b0000) begin
                failures++;
                $display("FAIL release_%0d: got grant %b exp 0000", k, grant);
            end
            cycle();
            checks++;
            if (grant !== 4'b0000) begin
                failures++;
                $display("FAIL gap_%0d: got grant %b exp 0000", k, grant);
            end
            cycle();
            checks++;
            if (grant !== nxt[k]) begin
                failures++;
                $display("FAIL next_grant_%0d: got %b exp %b", k, grant, nxt[k]);
            end
        end
        checks++;
        if (dut.state_q !== S_IDLE || exp_q.size() != 0) begin
            failures++;
            $display("FAIL simul_idle: state=%0d pending=%0d exp 0 0", dut.state_q, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit found;
        for (int c = 0; c < 3; c++) hdr[c] = '0;
        req_valid = 4'b1111; cycle();
        req_valid = 4'b1111; cycle();
        req_valid = 4'b0001; cycle();
        req_valid = 4'b0111;
        #1;
        checks++;
        if (req_ready !== 1'b0 || seq_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL bp_blocked: ready=%b wr_en=%b exp 0 0", req_ready, seq_wr_en);
        end
        repeat (3) cycle();
        hdr[0] = 8'd1;
        found  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            auto_done();
            #1;
            if (req_ready === 1'b1) begin
                found = 1'b1;
                checks++;
                if (seq_wr_en !== 1'b1 || seq_wr_mode !== 3'd3) begin
                    failures++;
                    $display("FAIL bp_accept: wr_en=%b mode=%0d exp 1 3", seq_wr_en, seq_wr_mode);
                end
            end
            cycle();
            if (found) break;
        end
        req_valid = 4'b0000;
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL bp_timeout: write never accepted after pop");
        end
        if (tlp_done) auto_done();
        set_credits_max();
        drain(300);
    endtask

    task automatic test_credit_stall();
        set_credits_max();
        hdr[1]    = '0;
        req_valid = 4'b0010;
        cycle();
        req_valid = 4'b0000;
        repeat (6) cycle();
        checks++;
        if (grant !== 4'b0000 || dut.state_q !== S_CHECK) begin
            failures++;
            $display("FAIL stall_hold: grant=%b state=%0d exp 0000 CHECK", grant, dut.state_q);
        end
        hdr[1] = 8'd1;
        cycle();
        checks++;
        if (grant !== 4'b0010 || cr_consume_vld !== 1'b1 || cr_consume_class !== 2'd1) begin
            failures++;
            $display("FAIL stall_release: grant=%b vld=%b class=%0d exp 0010 1 1", grant, cr_consume_vld, cr_consume_class);
        end
        cycle();
        checks++;
        if (cr_consume_vld !== 1'b0 || grant !== 4'b0010) begin
            failures++;
            $display("FAIL stall_pulse: vld=%b grant=%b exp 0 0010", cr_consume_vld, grant);
        end
        drain(50);
    endtask

    task automatic test_data_credits();
        set_credits_max();
        need[2]   = 12'd16;
        dcr[2]    = 12'd15;
        req_valid = 4'b0100;
        cycle();
        req_valid = 4'b0000;
        repeat (6) cycle();
        checks++;
        if (grant !== 4'b0000) begin
            failures++;
            $display("FAIL data_short: got grant %b exp 0000", grant);
        end
        dcr[2] = 12'd16;
        cycle();
        checks++;
        if (grant !== 4'b0100 || cr_consume_data !== 12'd16 || cr_consume_class !== 2'd2) begin
            failures++;
            $display("FAIL data_exact: grant=%b data=%0d class=%0d exp 0100 16 2", grant, cr_consume_data, cr_consume_class);
        end
        drain(50);
    endtask

    task automatic test_queue_drain();
        for (int c = 0; c < 3; c++) hdr[c] = '0;
        for (int i = 0; i < 40 && fcount != DEPTH; i++) begin
            req_valid = 4'($urandom_range(1, 15));
            cycle();
        end
        req_valid = 4'b0001;
        #1;
        checks++;
        if (fcount != DEPTH || req_ready !== 1'b0 || seq_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL full_block: stored=%0d ready=%b wr_en=%b exp %0d 0 0", fcount, req_ready, seq_wr_en, DEPTH);
        end
        cycle();
        req_valid = 4'b0000;
        set_credits_max();
        drain(400);
        checks++;
        if (dut.state_q !== S_IDLE || seq_rd_en !== 1'b0 || grant !== 4'b0000) begin
            failures++;
            $display("FAIL drain_idle: state=%0d rd_en=%b grant=%b exp IDLE 0 0000", dut.state_q, seq_rd_en, grant);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) need[k] = 12'($urandom_range(0, 64));
        for (int it = 0; it < 300; it++) begin
            req_valid = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            for (int c = 0; c < 3; c++) begin
                hdr[c] = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                dcr[c] = 12'($urandom_range(0, 100));
            end
            auto_done();
            cycle();
        end
        req_valid = 4'b0000;
        set_credits_max();
        drain(400);
    endtask

    task automatic test_reset_mid_xmit();
        bit seen;
        set_credits_max();
        req_valid = 4'b0100;
        cycle();
        req_valid = 4'b0000;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            if (grant == 4'b0100) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rst_setup: grant 0100 never seen, got %b", grant);
        end
        #2;
        arst = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || proto_err !== 1'b0 || dut.state_q !== S_IDLE || cr_consume_vld !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_xmit: grant=%b err=%b state=%0d vld=%b exp 0000 0 IDLE 0",
                     grant, proto_err, dut.state_q, cr_consume_vld);
        end
        exp_q.delete();
        tlp_done = 1'b0;
        hold     = 0;
        @(negedge clk);
        arst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_proto_err();
        tlp_done = 1'b1;
        cycle();
        tlp_done = 1'b0;
        checks++;
        if (proto_err !== 1'b1) begin
            failures++;
            $display("FAIL proto_set: got %b exp 1", proto_err);
        end
        repeat (3) cycle();
        checks++;
        if (proto_err !== 1'b1) begin
            failures++;
            $display("FAIL proto_sticky: got %b exp 1", proto_err);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) need[k] = 12'd8;
        set_credits_max();
        test_reset();
        test_simultaneous();
        test_backpressure();
        test_credit_stall();
        test_data_credits();
        test_queue_drain();
        test_random();
        test_reset_mid_xmit();
        test_proto_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
